// File: rtl/pipeline_stall_ctrl.sv
// Decode-stage stall/flush controller: turns hazard-unit outputs into pipeline
// register enables, next-PC selection and hazard-clear pulses.
module pipeline_stall_ctrl #(
    parameter int unsigned WAIT_MAX = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_hazard,
    input  logic             control_hazard,
    input  logic             id_branch,
    input  logic             id_call,
    input  logic             id_ret,
    input  logic             ex_branch_valid,
    input  logic             ex_branch_taken,
    input  logic             mem_call_done,
    input  logic             wb_ret_done,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             clr_branch_haz,
    output logic             clr_call_haz,
    output logic             clr_ret_haz,
    output logic [CNT_W-1:0] data_stall_cnt,
    output logic [CNT_W-1:0] ctrl_flush_cnt,
    output logic             timeout_err
);

    localparam int unsigned WW = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT_BR,
        S_WAIT_CALL,
        S_WAIT_RET
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WW-1:0]    r_wait_cnt;
    logic [CNT_W-1:0] r_data_stall_cnt;
    logic [CNT_W-1:0] r_ctrl_flush_cnt;
    logic             r_timeout_err;
    logic             w_last;
    logic             w_set_err;

    // The increment taken this cycle is the one that reaches WAIT_MAX.
    assign w_last = (r_wait_cnt == WAIT_LAST);

    always_comb begin
        w_next         = r_state;
        w_set_err      = 1'b0;
        pc_we          = 1'b1;
        pc_src         = 2'b00;
        ifid_we        = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        clr_branch_haz = 1'b0;
        clr_call_haz   = 1'b0;
        clr_ret_haz    = 1'b0;
        case (r_state)
            S_RUN: begin
                if (data_hazard) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                end else if (id_ret || id_call || id_branch || control_hazard) begin
                    pc_we      = 1'b0;
                    ifid_flush = 1'b1;
                    if (id_ret)         w_next = S_WAIT_RET;
                    else if (id_call)   w_next = S_WAIT_CALL;
                    else if (id_branch) w_next = S_WAIT_BR;
                end
            end
            S_WAIT_BR: begin
                pc_we      = 1'b0;
                ifid_flush = 1'b1;
                if (ex_branch_valid) begin
                    clr_branch_haz = 1'b1;
                    ifid_flush     = 1'b0;
                    w_next         = S_RUN;
                    if (ex_branch_taken) begin
                        pc_we  = 1'b1;
                        pc_src = 2'b01;
                    end
                end else if (w_last) begin
                    clr_branch_haz = 1'b1;
                    ifid_flush     = 1'b0;
                    w_set_err      = 1'b1;
                    w_next         = S_RUN;
                end
            end
            S_WAIT_CALL: begin
                pc_we      = 1'b0;
                ifid_flush = 1'b1;
                if (mem_call_done) begin
                    clr_call_haz = 1'b1;
                    pc_we        = 1'b1;
                    pc_src       = 2'b10;
                    ifid_flush   = 1'b0;
                    w_next       = S_RUN;
                end else if (w_last) begin
                    clr_call_haz = 1'b1;
                    ifid_flush   = 1'b0;
                    w_set_err    = 1'b1;
                    w_next       = S_RUN;
                end
            end
            S_WAIT_RET: begin
                pc_we      = 1'b0;
                ifid_flush = 1'b1;
                if (wb_ret_done) begin
                    clr_ret_haz = 1'b1;
                    pc_we       = 1'b1;
                    pc_src      = 2'b11;
                    ifid_flush  = 1'b0;
                    w_next      = S_RUN;
                end else if (w_last) begin
                    clr_ret_haz = 1'b1;
                    ifid_flush  = 1'b0;
                    w_set_err   = 1'b1;
                    w_next      = S_RUN;
                end
            end
            default: w_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_RUN;
            r_wait_cnt       <= '0;
            r_data_stall_cnt <= '0;
            r_ctrl_flush_cnt <= '0;
            r_timeout_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            // Held at zero in RUN, so every WAIT entry starts from zero.
            if (r_state == S_RUN) r_wait_cnt <= '0;
            else                  r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_state == S_RUN && data_hazard && r_data_stall_cnt != '1)
                r_data_stall_cnt <= r_data_stall_cnt + 1'b1;
            if (ifid_flush && r_ctrl_flush_cnt != '1)
                r_ctrl_flush_cnt <= r_ctrl_flush_cnt + 1'b1;
            if (w_set_err) r_timeout_err <= 1'b1;
        end
    end

    assign data_stall_cnt = r_data_stall_cnt;
    assign ctrl_flush_cnt = r_ctrl_flush_cnt;
    assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (WAIT_MAX=8, CNT_W=4).
module tb_pipeline_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_hazard, control_hazard, id_branch, id_call, id_ret;
    logic       ex_branch_valid, ex_branch_taken, mem_call_done, wb_ret_done;
    logic       pc_we, ifid_we, ifid_flush, idex_bubble;
    logic [1:0] pc_src;
    logic       clr_branch_haz, clr_call_haz, clr_ret_haz;
    logic [3:0] data_stall_cnt, ctrl_flush_cnt;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    pipeline_stall_ctrl #(.WAIT_MAX(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .data_hazard(data_hazard), .control_hazard(control_hazard),
        .id_branch(id_branch), .id_call(id_call), .id_ret(id_ret),
        .ex_branch_valid(ex_branch_valid), .ex_branch_taken(ex_branch_taken),
        .mem_call_done(mem_call_done), .wb_ret_done(wb_ret_done),
        .pc_we(pc_we), .pc_src(pc_src), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .clr_branch_haz(clr_branch_haz), .clr_call_haz(clr_call_haz),
        .clr_ret_haz(clr_ret_haz),
        .data_stall_cnt(data_stall_cnt), .ctrl_flush_cnt(ctrl_flush_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // dh ch br call ret bv bt mc wr
    task automatic drive(input logic [8:0] v);
        {data_hazard, control_hazard, id_branch, id_call, id_ret,
         ex_branch_valid, ex_branch_taken, mem_call_done, wb_ret_done} = v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pc_we, pc_src, ifid_we, ifid_flush, idex_bubble, clr {br,call,ret}
    task automatic chk_out(input string tag, input logic we, input logic [1:0] src,
                           input logic fwe, input logic fl, input logic bub,
                           input logic [2:0] clr);
        chk({tag, ".pc_we"}, 16'(pc_we), 16'(we));
        chk({tag, ".pc_src"}, 16'(pc_src), 16'(src));
        chk({tag, ".ifid_we"}, 16'(ifid_we), 16'(fwe));
        chk({tag, ".ifid_flush"}, 16'(ifid_flush), 16'(fl));
        chk({tag, ".idex_bubble"}, 16'(idex_bubble), 16'(bub));
        chk({tag, ".clr"}, 16'({clr_branch_haz, clr_call_haz, clr_ret_haz}), 16'(clr));
    endtask

    initial begin
        rst = 1'b1;
        drive(9'b0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk_out("reset_idle", 1, 2'b00, 1, 0, 0, 3'b000);
        chk("reset.stall_cnt", 16'(data_stall_cnt), 16'd0);
        chk("reset.flush_cnt", 16'(ctrl_flush_cnt), 16'd0);
        chk("reset.err", 16'(timeout_err), 16'd0);

        // Data hazard holds a branch in decode for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(9'b101000000);
            chk_out("dhaz", 0, 2'b00, 0, 0, 1, 3'b000);
            tick();
        end
        chk("dhaz.stall_cnt", 16'(data_stall_cnt), 16'd3);
        drive(9'b001000000);
        chk_out("br_issue", 0, 2'b00, 1, 1, 0, 3'b000);
        tick();
        drive(9'b0);
        chk_out("wait_br", 0, 2'b00, 1, 1, 0, 3'b000);
        tick();
        drive(9'b000001100);
        chk_out("br_taken", 1, 2'b01, 1, 0, 0, 3'b100);
        tick();
        chk("br_taken.flush_cnt", 16'(ctrl_flush_cnt), 16'd2);
        drive(9'b0);
        chk_out("br_after", 1, 2'b00, 1, 0, 0, 3'b000);

        // Not-taken branch
        drive(9'b001000000); tick();
        drive(9'b000001000);
        chk_out("br_nt", 0, 2'b00, 1, 0, 0, 3'b100);
        tick();
        drive(9'b0);
        chk_out("br_nt_after", 1, 2'b00, 1, 0, 0, 3'b000);
        chk("br_nt.flush_cnt", 16'(ctrl_flush_cnt), 16'd3);

        // Call resolved after three wait cycles
        drive(9'b000100000); tick();
        for (int i = 0; i < 3; i++) begin
            drive(9'b0);
            chk_out("wait_call", 0, 2'b00, 1, 1, 0, 3'b000);
            tick();
        end
        drive(9'b000000010);
        chk_out("call_done", 1, 2'b10, 1, 0, 0, 3'b010);
        tick();

        // Return with a spurious branch resolution in between
        drive(9'b000010000); tick();
        drive(9'b000001100);
        chk_out("ret_spurious_br", 0, 2'b00, 1, 1, 0, 3'b000);
        tick();
        drive(9'b000000001);
        chk_out("ret_done", 1, 2'b11, 1, 0, 0, 3'b001);
        tick();

        // ret beats call beats branch when all are decoded together
        drive(9'b001110000); tick();
        drive(9'b000000010);
        chk_out("prio_call_ignored", 0, 2'b00, 1, 1, 0, 3'b000);
        tick();
        drive(9'b000000001);
        chk_out("prio_ret_done", 1, 2'b11, 1, 0, 0, 3'b001);
        tick();

        // Inconsistent control_hazard in RUN
        drive(9'b010000000);
        chk_out("ctl_incons", 0, 2'b00, 1, 1, 0, 3'b000);
        tick();
        drive(9'b0);
        chk_out("ctl_incons_after", 1, 2'b00, 1, 0, 0, 3'b000);
        chk("incons.flush_cnt", 16'(ctrl_flush_cnt), 16'd12);

        // Resolution on the 8th wait cycle wins over timeout
        drive(9'b000100000); tick();
        for (int i = 0; i < 7; i++) begin drive(9'b0); tick(); end
        drive(9'b000000010);
        chk_out("call_edge_resolve", 1, 2'b10, 1, 0, 0, 3'b010);
        tick();
        chk("edge.err", 16'(timeout_err), 16'd0);

        // Call never resolves: timeout on the 8th wait cycle
        drive(9'b000100000); tick();
        for (int i = 0; i < 7; i++) begin
            drive(9'b0);
            chk_out("call_wait_to", 0, 2'b00, 1, 1, 0, 3'b000);
            tick();
        end
        drive(9'b0);
        chk_out("call_timeout", 0, 2'b00, 1, 0, 0, 3'b010);
        chk("timeout.err_before", 16'(timeout_err), 16'd0);
        tick();
        chk("timeout.err", 16'(timeout_err), 16'd1);
        chk("flush_cnt_sat", 16'(ctrl_flush_cnt), 16'd15);
        chk_out("after_timeout", 1, 2'b00, 1, 0, 0, 3'b000);
        drive(9'b001000000); tick();
        drive(9'b000001100); tick();
        drive(9'b0);
        chk("err_sticky", 16'(timeout_err), 16'd1);

        // Reset clears everything, then saturate the stall counter
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("rst.err", 16'(timeout_err), 16'd0);
        chk("rst.flush_cnt", 16'(ctrl_flush_cnt), 16'd0);
        for (int i = 0; i < 20; i++) begin drive(9'b100000000); tick(); end
        chk("stall_cnt_sat", 16'(data_stall_cnt), 16'd15);

        // Asynchronous reset while waiting on a branch
        drive(9'b001000000); tick();
        drive(9'b000001100);
        chk_out("pre_rst_wait_br", 1, 2'b01, 1, 0, 0, 3'b100);
        rst = 1'b1;
        #1;
        chk_out("rst_in_wait", 1, 2'b00, 1, 0, 0, 3'b000);
        chk("rst_in_wait.stall_cnt", 16'(data_stall_cnt), 16'd0);
        chk("rst_in_wait.flush_cnt", 16'(ctrl_flush_cnt), 16'd0);
        drive(9'b0);
        tick();
        rst = 1'b0;
        #1;
        chk_out("post_rst", 1, 2'b00, 1, 0, 0, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
